// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the flip-flop register bank.
// Covers the index-width helper and the access-type encoding.
package dff_bank_arbiter_pkg;

    localparam logic ACC_RD = 1'b0;
    localparam logic ACC_WR = 1'b1;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int rr_idx_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the register bank arbiter.
// Carries the flat per-requester request fields, the grant vector and the shared read response.
interface dff_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int AW    = 3
) ();
    localparam int IDX_W = dff_bank_arbiter_pkg::rr_idx_w(N_REQ);

    // Handshake: requester i holds req/we/addr/wdata stable while req[i]=1.
    // The access is accepted in the cycle where req[i]&gnt[i]=1.
    // A read answers one cycle later with a single rvalid pulse; rvalid has no backpressure.
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    we;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic                rvalid;
    logic [IDX_W-1:0]    rid;
    logic [DW-1:0]       rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rid, rdata
    );
endinterface

// File: rtl/dff_bank_arbiter_bank.sv
// DEPTH x DW flip-flop register array with one write port and one registered read port.
// Async reset clears all entries and the read register.
module dff_bank_arbiter_bank #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    // rd_data only loads on a read, so it holds between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter giving N_REQ requesters one access per clock into a shared flip-flop bank.
// Writes commit at the grant edge; reads answer one cycle later with rvalid/rid/rdata.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    dff_bank_arbiter_if.slave  bus
);
    localparam int IDX_W = rr_idx_w(N_REQ);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_vec;
    logic             acc;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             wr_fire;
    logic             rd_fire;
    logic             rvalid_q;
    logic [IDX_W-1:0] rid_q;

    // First requesting index at or after ptr wins; nothing is granted while reset is high.
    always_comb begin
        cand    = '0;
        gnt_idx = '0;
        gnt_vec = '0;
        acc     = 1'b0;
        if (!reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % N_REQ);
                if (!acc && bus.req[cand]) begin
                    acc          = 1'b1;
                    gnt_idx      = cand;
                    gnt_vec[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_we    = ACC_RD;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_vec[i]) begin
                sel_we    = bus.we[i];
                sel_addr  = bus.addr[i*AW +: AW];
                sel_wdata = bus.wdata[i*DW +: DW];
            end
        end
    end

    assign wr_fire = acc && (sel_we == ACC_WR);
    assign rd_fire = acc && (sel_we == ACC_RD);

    // rvalid is a one-cycle echo of a granted read; rid holds with rdata between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= rd_fire;
            if (rd_fire) begin
                rid_q <= gnt_idx;
            end
            if (acc) begin
                ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    dff_bank_arbiter_bank #(
        .DW (DW),
        .AW (AW)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire),
        .wr_addr (sel_addr),
        .wr_data (sel_wdata),
        .rd_en   (rd_fire),
        .rd_addr (sel_addr),
        .rd_data (bus.rdata)
    );

    assign bus.gnt    = gnt_vec;
    assign bus.rvalid = rvalid_q;
    assign bus.rid    = rid_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios plus a random phase,
// with read responses checked against a reference memory through an expected queue.
module tb_dff_bank_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .AW(AW)) bus ();

    dff_bank_arbiter #(.N_REQ(N_REQ), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_ptr = 0;
    logic [7:0]  m_mem [8];
    logic [9:0]  exp_q [$];
    logic [9:0]  e_mon;

    // Response monitor: every queued read must answer at the next falling edge, nothing else may.
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                n_cmp++;
                if (bus.rvalid !== 1'b1 || {bus.rid, bus.rdata} !== e_mon) begin
                    n_bad++;
                    $display("FAIL read_resp: got rvalid=%0b rid=%0d rdata=%02h, want rvalid=1 rid=%0d rdata=%02h",
                             bus.rvalid, bus.rid, bus.rdata, e_mon[9:8], e_mon[7:0]);
                end
            end else if (bus.rvalid !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_rvalid: got rvalid=%0b rid=%0d, want rvalid=0", bus.rvalid, bus.rid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] model_gnt(input int p, input logic [3:0] r);
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (p + k) % N_REQ;
            if (r[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        exp_q.delete();
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] w,
                         input logic [11:0] a, input logic [31:0] d);
        bus.req   = r;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        #1;
    endtask

    // Advances the reference model for the current inputs, then moves to the next cycle.
    task automatic commit();
        logic [3:0] g;
        logic [2:0] a;
        g = model_gnt(m_ptr, bus.req);
        for (int i = 0; i < N_REQ; i++) begin
            if (g[i]) begin
                a = bus.addr[i*3 +: 3];
                if (bus.we[i]) m_mem[a] = bus.wdata[i*8 +: 8];
                else exp_q.push_back({2'(i), m_mem[a]});
                m_ptr = (i + 1) % N_REQ;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drive(4'b1111, 4'b0000, 12'h000, 32'h0);
        n_cmp++;
        if (bus.gnt !== 4'b0000 || bus.rvalid !== 1'b0 || bus.rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL in_reset: got gnt=%b rvalid=%0b rdata=%02h, want 0000/0/00", bus.gnt, bus.rvalid, bus.rdata);
        end
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0000, 4'b0000, 12'h000, 32'h0);
            n_cmp++;
            if (bus.gnt !== 4'b0000 || bus.rvalid !== 1'b0 || bus.rdata !== 8'h00 || bus.rid !== 2'd0) begin
                n_bad++;
                $display("FAIL idle_%0d: got gnt=%b rvalid=%0b rid=%0d rdata=%02h, want 0000/0/0/00",
                         c, bus.gnt, bus.rvalid, bus.rid, bus.rdata);
            end
            commit();
        end
        drive(4'b1111, 4'b0000, 12'h000, 32'h0);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL ptr_after_idle: got gnt=%b, want 0001", bus.gnt);
        end
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        commit();
    endtask

    task automatic test_write_read();
        drive(4'b0001, 4'b0001, {9'd0, 3'd3}, {24'h0, 8'hA5});
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL wr_gnt: got gnt=%b, want 0001", bus.gnt);
        end
        commit();
        drive(4'b0001, 4'b0000, {9'd0, 3'd3}, 32'h0);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL rd_gnt: got gnt=%b, want 0001", bus.gnt);
        end
        commit();
        n_cmp++;
        if (bus.rvalid !== 1'b1 || bus.rid !== 2'd0 || bus.rdata !== 8'hA5) begin
            n_bad++;
            $display("FAIL raw_same: got rvalid=%0b rid=%0d rdata=%02h, want 1/0/a5", bus.rvalid, bus.rid, bus.rdata);
        end
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        commit();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, (c < 4) ? 4'b1111 : 4'b0000, {3'd3, 3'd2, 3'd1, 3'd0}, 32'hD4C3B2A1);
            exp_g = 4'b0001 << (c % 4);
            n_cmp++;
            if (bus.gnt !== exp_g) begin
                n_bad++;
                $display("FAIL rr_cycle_%0d: got gnt=%b, want %b", c, bus.gnt, exp_g);
            end
            commit();
        end
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        commit();
    endtask

    task automatic test_wrap();
        drive(4'b0100, 4'b0100, {3'd0, 3'd7, 6'd0}, {8'h00, 8'h77, 16'h0});
        n_cmp++;
        if (bus.gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL wrap_setup: got gnt=%b, want 0100", bus.gnt);
        end
        commit();
        drive(4'b1001, 4'b0000, {3'd7, 6'd0, 3'd3}, 32'h0);
        n_cmp++;
        if (bus.gnt !== 4'b1000) begin
            n_bad++;
            $display("FAIL wrap_top: got gnt=%b, want 1000", bus.gnt);
        end
        commit();
        drive(4'b1001, 4'b0000, {3'd7, 6'd0, 3'd3}, 32'h0);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap_zero: got gnt=%b, want 0001", bus.gnt);
        end
        commit();
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        commit();
    endtask

    task automatic test_raw_cross();
        drive(4'b0010, 4'b0010, {6'd0, 3'd5, 3'd0}, {16'h0, 8'h3C, 8'h00});
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL cross_wr_gnt: got gnt=%b, want 0010", bus.gnt);
        end
        commit();
        drive(4'b0100, 4'b0000, {3'd0, 3'd5, 6'd0}, 32'h0);
        n_cmp++;
        if (bus.gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL cross_rd_gnt: got gnt=%b, want 0100", bus.gnt);
        end
        commit();
        n_cmp++;
        if (bus.rvalid !== 1'b1 || bus.rid !== 2'd2 || bus.rdata !== 8'h3C) begin
            n_bad++;
            $display("FAIL raw_cross: got rvalid=%0b rid=%0d rdata=%02h, want 1/2/3c", bus.rvalid, bus.rid, bus.rdata);
        end
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        commit();
    endtask

    task automatic test_reset_midflight();
        drive(4'b0001, 4'b0000, {9'd0, 3'd1}, 32'h0);
        commit();
        drive(4'b0001, 4'b0000, {9'd0, 3'd2}, 32'h0);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL mid_gnt: got gnt=%b, want 0001", bus.gnt);
        end
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (bus.gnt !== 4'b0000 || bus.rvalid !== 1'b0 || bus.rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL async_clear: got gnt=%b rvalid=%0b rdata=%02h, want 0000/0/00", bus.gnt, bus.rvalid, bus.rdata);
        end
        reset = 1'b0;
        bus.req = 4'b0000;
        #1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL dropped_resp: got rvalid=%0b, want 0", bus.rvalid);
        end
        drive(4'b0001, 4'b0000, {9'd0, 3'd1}, 32'h0);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL post_reset_gnt: got gnt=%b, want 0001", bus.gnt);
        end
        commit();
        n_cmp++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL bank_cleared: got rvalid=%0b rdata=%02h, want 1/00", bus.rvalid, bus.rdata);
        end
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        commit();
    endtask

    task automatic test_random();
        logic [3:0]  pend;
        logic [3:0]  pw;
        logic [11:0] pa;
        logic [31:0] pd;
        logic [3:0]  exp_g;
        pend = '0;
        pw   = '0;
        pa   = '0;
        pd   = '0;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    pend[i]        = 1'b1;
                    pw[i]          = 1'($urandom_range(0, 1));
                    pa[i*3 +: 3]   = 3'($urandom_range(0, 3));
                    pd[i*8 +: 8]   = 8'($urandom_range(0, 255));
                end else if (pend[i] && $urandom_range(0, 99) < 5) begin
                    pend[i] = 1'b0;
                end
            end
            drive(pend, pw, pa, pd);
            exp_g = model_gnt(m_ptr, pend);
            n_cmp++;
            if (bus.gnt !== exp_g) begin
                n_bad++;
                $display("FAIL rand_gnt_%0d: got gnt=%b, want %b", c, bus.gnt, exp_g);
            end
            commit();
            pend = pend & ~exp_g;
        end
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        commit();
    endtask

    initial begin
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        reset     = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
        @(negedge clk);
        #1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_wrap();
        test_raw_cross();
        test_reset_midflight();
        test_random();
        drive(4'b0000, 4'b0000, 12'h000, 32'h0);
        commit();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL drain: got %0d outstanding reads, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
